// File: rtl/fft_mc_pkg.sv
// -----------------------------------------------------------------------------
// fft_mc_pkg
// Shared types and sizes for the memory-controller-side FFT streaming engine.
//   - state_e   : job sequencer states
//   - LINE_W    : width of one host/accelerator data line
//   - SIGNUM_W  : width of the job signal number
//   - LINES     : lines per signal in each direction (power of two)
//   - IDX_W     : log2(LINES), width of the line index
//   - ADDR_W    : host line address width, {signal number, line index}
// -----------------------------------------------------------------------------
package fft_mc_pkg;

    localparam int LINE_W   = 512;
    localparam int SIGNUM_W = 18;
    localparam int LINES    = 128;
    localparam int IDX_W    = 7;
    localparam int ADDR_W   = 25;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        KICK     = 4'd1,
        RD_REQ   = 4'd2,
        RD_PUSH  = 4'd3,
        WAIT_OUT = 4'd4,
        POP      = 4'd5,
        POP_WAIT = 4'd6,
        WR       = 4'd7,
        DONE     = 4'd8
    } state_e;

    // Host line address: the signal number selects a 128-line block.
    function automatic logic [ADDR_W-1:0] make_addr(
        input logic [SIGNUM_W-1:0] sig,
        input logic [IDX_W-1:0]    idx
    );
        return {sig, idx};
    endfunction

endpackage

// File: rtl/fft_mc_stream.sv
// -----------------------------------------------------------------------------
// fft_mc_stream
// Runs one FFT job per accepted start: pulses the accelerator start, streams
// LINES host lines into the accelerator input FIFO, then pops LINES result
// lines from the accelerator output FIFO and writes them back to host memory.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   start, sigNum       : job request (honoured only when idle) and its signal
//   busy, jobDone       : engine status / end-of-job pulse
//   memRd*              : host read channel  (req held until memRdValid)
//   memWr*              : host write channel (req held until memWrAck)
//   startF, sigNumAcc   : accelerator start pulse and job signal number
//   loadInFifo, mcDataIn: push of one line into the accelerator input FIFO
//   outFifoReady        : accelerator has a complete result available
//   accelWrBlkDone      : pop request to the accelerator output FIFO
//   mcDataOutValid/Out  : popped result line
//
// All outputs come straight from flops: control strobes are registered from
// the next-state decode so they line up with the state they belong to, and
// addresses/data are built from the signal-number, index and line registers.
// A single line register serves both the read path and the write path since
// the two phases never overlap.
// -----------------------------------------------------------------------------
module fft_mc_stream
    import fft_mc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SIGNUM_W-1:0] sigNum,
    output logic                busy,
    output logic                jobDone,
    output logic                memRdReq,
    output logic [ADDR_W-1:0]   memRdAddr,
    input  logic                memRdValid,
    input  logic [LINE_W-1:0]   memRdData,
    output logic                memWrReq,
    output logic [ADDR_W-1:0]   memWrAddr,
    output logic [LINE_W-1:0]   memWrData,
    input  logic                memWrAck,
    output logic                startF,
    output logic [SIGNUM_W-1:0] sigNumAcc,
    output logic                loadInFifo,
    output logic [LINE_W-1:0]   mcDataIn,
    input  logic                outFifoReady,
    output logic                accelWrBlkDone,
    input  logic                mcDataOutValid,
    input  logic [LINE_W-1:0]   mcDataOut
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      line_idx_q, line_idx_d;
    logic [SIGNUM_W-1:0]   sig_num_q, sig_num_d;
    logic [LINE_W-1:0]     line_q, line_d;

    logic                  busy_q, busy_d;
    logic                  job_done_q, job_done_d;
    logic                  rd_req_q, rd_req_d;
    logic                  wr_req_q, wr_req_d;
    logic                  start_f_q, start_f_d;
    logic                  load_q, load_d;
    logic                  pop_q, pop_d;

    logic                  last_line_s;

    assign last_line_s = (line_idx_q == LAST_IDX);

    // Next-state, index, signal-number and line-register computation.
    always_comb begin
        state_d    = state_q;
        line_idx_d = line_idx_q;
        sig_num_d  = sig_num_q;
        line_d     = line_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sig_num_d  = sigNum;
                    line_idx_d = '0;
                    state_d    = KICK;
                end else begin
                    state_d    = IDLE;
                end
            end
            KICK: begin
                state_d = RD_REQ;
            end
            RD_REQ: begin
                if (memRdValid) begin
                    line_d  = memRdData;
                    state_d = RD_PUSH;
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_PUSH: begin
                // The index is reused for the write-back phase, so wrap it
                // explicitly instead of letting it overflow.
                if (last_line_s) begin
                    line_idx_d = '0;
                    state_d    = WAIT_OUT;
                end else begin
                    line_idx_d = line_idx_q + ONE_IDX;
                    state_d    = RD_REQ;
                end
            end
            WAIT_OUT: begin
                if (outFifoReady) begin
                    state_d = POP;
                end else begin
                    state_d = WAIT_OUT;
                end
            end
            POP: begin
                state_d = POP_WAIT;
            end
            POP_WAIT: begin
                if (mcDataOutValid) begin
                    line_d  = mcDataOut;
                    state_d = WR;
                end else begin
                    state_d = POP_WAIT;
                end
            end
            WR: begin
                if (memWrAck) begin
                    if (last_line_s) begin
                        state_d    = DONE;
                    end else begin
                        line_idx_d = line_idx_q + ONE_IDX;
                        state_d    = POP;
                    end
                end else begin
                    state_d = WR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output strobes decoded from the next state so the registered copy is
    // valid in exactly the cycle the FSM occupies that state.
    always_comb begin
        busy_d     = (state_d != IDLE);
        job_done_d = (state_d == DONE);
        rd_req_d   = (state_d == RD_REQ);
        wr_req_d   = (state_d == WR);
        start_f_d  = (state_d == KICK);
        load_d     = (state_d == RD_PUSH);
        pop_d      = (state_d == POP);
    end

    // State, datapath and output registers; reset clears every output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            line_idx_q <= '0;
            sig_num_q  <= '0;
            line_q     <= '0;
            busy_q     <= 1'b0;
            job_done_q <= 1'b0;
            rd_req_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            start_f_q  <= 1'b0;
            load_q     <= 1'b0;
            pop_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_idx_q <= line_idx_d;
            sig_num_q  <= sig_num_d;
            line_q     <= line_d;
            busy_q     <= busy_d;
            job_done_q <= job_done_d;
            rd_req_q   <= rd_req_d;
            wr_req_q   <= wr_req_d;
            start_f_q  <= start_f_d;
            load_q     <= load_d;
            pop_q      <= pop_d;
        end
    end

    assign busy           = busy_q;
    assign jobDone        = job_done_q;
    assign memRdReq       = rd_req_q;
    assign memWrReq       = wr_req_q;
    assign startF         = start_f_q;
    assign loadInFifo     = load_q;
    assign accelWrBlkDone = pop_q;

    // Addresses and data are pure flop concatenations, so they are zero out
    // of reset and stay stable for as long as a request is held.
    assign memRdAddr = make_addr(sig_num_q, line_idx_q);
    assign memWrAddr = make_addr(sig_num_q, line_idx_q);
    assign memWrData = line_q;
    assign mcDataIn  = line_q;
    assign sigNumAcc = sig_num_q;

endmodule

// File: tb/tb_fft_mc_stream.sv
// -----------------------------------------------------------------------------
// tb_fft_mc_stream
// Drives fft_mc_stream with a host-memory and accelerator model that answers
// requests after random latencies, and compares every push, pop and write
// against per-job tables of expected lines and addresses.
// -----------------------------------------------------------------------------
module tb_fft_mc_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [17:0]  sigNum;
    logic         busy;
    logic         jobDone;
    logic         memRdReq;
    logic [24:0]  memRdAddr;
    logic         memRdValid;
    logic [511:0] memRdData;
    logic         memWrReq;
    logic [24:0]  memWrAddr;
    logic [511:0] memWrData;
    logic         memWrAck;
    logic         startF;
    logic [17:0]  sigNumAcc;
    logic         loadInFifo;
    logic [511:0] mcDataIn;
    logic         outFifoReady;
    logic         accelWrBlkDone;
    logic         mcDataOutValid;
    logic [511:0] mcDataOut;

    int checks = 0;
    int errors = 0;

    logic [511:0] rd_mem  [128];
    logic [511:0] res_mem [128];

    localparam logic [511:0] JUNK = {16{32'hDEAD_BEEF}};

    always #5 clk = ~clk;

    fft_mc_stream dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .sigNum         (sigNum),
        .busy           (busy),
        .jobDone        (jobDone),
        .memRdReq       (memRdReq),
        .memRdAddr      (memRdAddr),
        .memRdValid     (memRdValid),
        .memRdData      (memRdData),
        .memWrReq       (memWrReq),
        .memWrAddr      (memWrAddr),
        .memWrData      (memWrData),
        .memWrAck       (memWrAck),
        .startF         (startF),
        .sigNumAcc      (sigNumAcc),
        .loadInFifo     (loadInFifo),
        .mcDataIn       (mcDataIn),
        .outFifoReady   (outFifoReady),
        .accelWrBlkDone (accelWrBlkDone),
        .mcDataOutValid (mcDataOutValid),
        .mcDataOut      (mcDataOut)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      busy, 1'b0);
        chk({tag, "_jobDone"},   jobDone, 1'b0);
        chk({tag, "_rdReq"},     memRdReq, 1'b0);
        chk({tag, "_rdAddr"},    memRdAddr, 25'd0);
        chk({tag, "_wrReq"},     memWrReq, 1'b0);
        chk({tag, "_wrAddr"},    memWrAddr, 25'd0);
        chk({tag, "_wrData"},    memWrData, 512'd0);
        chk({tag, "_startF"},    startF, 1'b0);
        chk({tag, "_sigNumAcc"}, sigNumAcc, 18'd0);
        chk({tag, "_load"},      loadInFifo, 1'b0);
        chk({tag, "_mcDataIn"},  mcDataIn, 512'd0);
        chk({tag, "_pop"},       accelWrBlkDone, 1'b0);
    endtask

    task automatic clear_inputs();
        start          = 1'b0;
        sigNum         = 18'd0;
        memRdValid     = 1'b0;
        memRdData      = 512'd0;
        memWrAck       = 1'b0;
        outFifoReady   = 1'b0;
        mcDataOutValid = 1'b0;
        mcDataOut      = 512'd0;
    endtask

    // One job: memory and accelerator answer with latencies up to lat_max.
    // rst_at >= 0 pulls reset while line rst_at is being written.
    task automatic run_job(input logic [17:0] sig, input int lat_max, input bit spurious,
                           input bit mid_start, input int rst_at);
        int rd_lat, ack_lat, val_lat, ready_cnt;
        int rd_cnt, push_cnt, pop_cnt, wr_cnt;
        bit exp_push, exp_wr, exp_done, pop_pend, pop_new;
        bit wr_hold_vld, done_seen, mid_done, aborted;
        logic [511:0] wr_hold;

        rd_lat = -1; ack_lat = -1; val_lat = 0;
        ready_cnt = spurious ? 4 : int'($urandom_range(lat_max, 0));
        rd_cnt = 0; push_cnt = 0; pop_cnt = 0; wr_cnt = 0;
        exp_push = 1'b0; exp_wr = 1'b0; exp_done = 1'b0; pop_pend = 1'b0; pop_new = 1'b0;
        wr_hold_vld = 1'b0; done_seen = 1'b0; mid_done = 1'b0; aborted = 1'b0;
        wr_hold = 512'd0;

        for (int k = 0; k < 128; k++) begin
            for (int w = 0; w < 16; w++) begin
                rd_mem[k][w*32 +: 32]  = $urandom();
                res_mem[k][w*32 +: 32] = $urandom();
            end
            if (lat_max == 0) rd_mem[k] = 512'(k);
        end

        @(negedge clk);
        start = 1'b1; sigNum = sig;
        @(negedge clk);
        chk("kick_startF", startF, 1'b1);
        chk("kick_sigNumAcc", sigNumAcc, sig);
        chk("kick_busy", busy, 1'b1);
        chk("kick_no_rdreq", memRdReq, 1'b0);
        start = 1'b0;

        for (int cyc = 0; cyc < 6000 && !done_seen && !aborted; cyc++) begin
            @(negedge clk);
            // ---- observe ----
            if (cyc == 0) chk("first_rdreq", memRdReq, 1'b1);
            chk("busy", busy, 1'b1);
            chk("no_second_startF", startF, 1'b0);
            chk("sigNumAcc_held", sigNumAcc, sig);
            chk("push_timing", loadInFifo, exp_push);
            exp_push = 1'b0;
            if (loadInFifo) begin
                chk("push_guard", push_cnt < 128, 1'b1);
                chk("push_after_read", rd_cnt, push_cnt + 1);
                if (push_cnt < 128) chk("push_data", mcDataIn, rd_mem[push_cnt]);
                push_cnt++;
            end
            if (exp_wr) chk("wr_timing", memWrReq, 1'b1);
            exp_wr = 1'b0;
            if (memWrReq) begin
                chk("wr_after_input", push_cnt, 128);
                if (wr_hold_vld) chk("wr_data_stable", memWrData, wr_hold);
            end
            chk("done_timing", jobDone, exp_done);
            pop_new = 1'b0;
            if (accelWrBlkDone) begin
                pop_cnt++;
                chk("pop_order", pop_cnt, wr_cnt + 1);
                pop_pend = 1'b1;
                pop_new  = 1'b1;
                val_lat  = int'($urandom_range(lat_max, 0));
            end

            // ---- respond ----
            memRdValid = 1'b0; mcDataOutValid = 1'b0; memWrAck = 1'b0; start = 1'b0;
            if (jobDone) begin
                chk("done_lines", wr_cnt, 128);
                done_seen = 1'b1;
                outFifoReady = 1'b0;
                if (mid_start) begin
                    start = 1'b1; sigNum = 18'h3FFFF;
                end
            end else if (rst_at >= 0 && memWrReq && wr_cnt == rst_at) begin
                rst = 1'b0;
                #1;
                chk_all_zero("rst_mid");
                clear_inputs();
                @(negedge clk);
                chk_all_zero("rst_hold");
                rst = 1'b1;
                aborted = 1'b1;
            end else begin
                if (mid_start && !mid_done && rd_cnt == 40) begin
                    start = 1'b1; sigNum = 18'h3FFFF; mid_done = 1'b1;
                end
                if (memRdReq) begin
                    if (rd_lat < 0) rd_lat = int'($urandom_range(lat_max, 0));
                    if (rd_lat == 0 && rd_cnt < 128) begin
                        chk("rd_addr", memRdAddr, {sig, 7'(rd_cnt)});
                        memRdValid = 1'b1;
                        memRdData  = rd_mem[rd_cnt];
                        rd_cnt++;
                        exp_push = 1'b1;
                        rd_lat   = -1;
                    end else begin
                        chk("rd_guard", rd_cnt < 128, 1'b1);
                        rd_lat--;
                        if (spurious) begin
                            mcDataOutValid = 1'b1; mcDataOut = JUNK;
                        end
                    end
                end
                if (push_cnt == 128 && pop_cnt == 0 && !outFifoReady) begin
                    if (ready_cnt == 0) begin
                        outFifoReady = 1'b1;
                    end else begin
                        ready_cnt--;
                        if (spurious) begin
                            memRdValid = 1'b1; memRdData = JUNK;
                        end
                    end
                end
                if (pop_pend && !pop_new) begin
                    if (val_lat == 0 && wr_cnt < 128) begin
                        mcDataOutValid = 1'b1;
                        mcDataOut      = res_mem[wr_cnt];
                        exp_wr   = 1'b1;
                        pop_pend = 1'b0;
                    end else begin
                        val_lat--;
                    end
                end
                if (memWrReq) begin
                    if (ack_lat < 0) ack_lat = int'($urandom_range(lat_max, 0));
                    if (ack_lat == 0 && wr_cnt < 128) begin
                        chk("wr_addr", memWrAddr, {sig, 7'(wr_cnt)});
                        chk("wr_data", memWrData, res_mem[wr_cnt]);
                        memWrAck = 1'b1;
                        wr_cnt++;
                        if (wr_cnt == 128) exp_done = 1'b1;
                        ack_lat = -1;
                        wr_hold_vld = 1'b0;
                    end else begin
                        ack_lat--;
                        wr_hold = memWrData;
                        wr_hold_vld = 1'b1;
                    end
                end else begin
                    wr_hold_vld = 1'b0;
                end
            end
        end

        if (!aborted) begin
            chk("job_finished", done_seen, 1'b1);
            chk("push_count", push_cnt, 128);
            chk("read_count", rd_cnt, 128);
            @(negedge clk);
            chk("post_done_busy", busy, 1'b0);
            chk("post_done_pulse", jobDone, 1'b0);
            chk("post_done_wrreq", memWrReq, 1'b0);
            start = 1'b0;
            @(negedge clk);
            chk("no_restart_startF", startF, 1'b0);
            chk("no_restart_busy", busy, 1'b0);
        end
        clear_inputs();
    endtask

    initial begin
        logic [17:0] s;
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Zero-latency job, data = line index.
        run_job(18'h00001, 0, 1'b0, 1'b0, -1);

        // Random latencies with start pulses mid-job and in the DONE cycle.
        s = 18'($urandom()); s[17] = 1'b0;
        run_job(s, 7, 1'b0, 1'b1, -1);

        // Random latencies with spurious valids in the wrong states.
        s = 18'($urandom()); s[17] = 1'b0;
        run_job(s, 7, 1'b1, 1'b0, -1);

        // Reset while writing line 60, then a clean job.
        run_job(18'h2AAAA, 3, 1'b0, 1'b0, 60);
        repeat (2) @(negedge clk);
        chk_all_zero("after_rst_idle");
        run_job(18'h00005, 2, 1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
